sccb_init_sequencer: RTL and testbench
======================================

Name: sccb_init_sequencer

Overview:
- Parametrised successor to the camera SCCB bring-up writer: a single block containing both the table walker and the 3-phase SCCB write engine.
- Walks an external register table (ROM) of 16-bit entries and issues one SCCB write per entry, with an inline millisecond-delay opcode and an end marker.
- Adds a restartable start handshake, busy/done status, an entry counter, and separate SIOD output-enable.
- Sits between the top-level reset/start logic and the camera sensor pins.

Parameters:
- CLK_FREQ, 12000000: clk frequency in Hz.
- SCCB_FREQ, 100000: SIOC frequency in Hz.
- Q: quarter bit period in cycles, CLK_FREQ/(4*SCCB_FREQ), integer division, minimum 1. Equals 30 at the defaults.
- POWERUP_DELAY, 10000: cycles to wait after start before the first fetch.
- DEV_ADDR, 8'h42: SCCB write device address (ID phase).
- ROM_AW, 8: table address width; depth is 2^ROM_AW.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- start, in, 1: rising edge (internally edge-detected) begins a sequence.
- rom_addr, out, ROM_AW: table address.
- rom_data, in, 16: entry {reg[15:8], val[7:0]}. Valid exactly 1 cycle after rom_addr changes.
- sioc, out, 1: SCCB clock.
- siod_o, out, 1: SCCB data value.
- siod_oe, out, 1: 1 = drive siod_o; 0 = release the line (pulled high).
- busy, out, 1: sequence in progress.
- done, out, 1: sequence complete; sticky until the next start.
- writes_done, out, ROM_AW+1: number of SCCB writes completed in the current run.
- debug_out, out, 32: {state[3:0], 3'b0, done, writes_done zero-extended to 8 bits, rom_addr zero-extended to 16 bits}.

Behaviour:
- Reset (rst=0, async): sioc=1, siod_o=1, siod_oe=0, busy=0, done=0, rom_addr=0, writes_done=0, state=IDLE, all counters 0.
- State machine: IDLE -> PWRUP -> FETCH -> WAITROM -> DECODE -> {TX | DELAY | DONE}. TX returns to FETCH via GAP; DELAY returns to FETCH.
- IDLE and DONE: a start rising edge does all of the following in one cycle:
  - busy=1, done=0, rom_addr=0, writes_done=0;
  - load the power-up counter with POWERUP_DELAY;
  - go to PWRUP.
- busy=1: start edges are ignored.
- PWRUP: count down to 0, then go to FETCH. POWERUP_DELAY=0 goes to FETCH on the next cycle.
- FETCH: present rom_addr, then go to WAITROM (1 cycle). WAITROM: go to DECODE. DECODE samples rom_data.
- DECODE decoding, first match wins:
  - 16'hFFFF: end marker. Go to DONE.
  - 16'hF0xx: delay xx ms. Load xx*(CLK_FREQ/1000) and go to DELAY. xx=0 goes straight to FETCH of the next entry.
  - Otherwise: SCCB write of reg=rom_data[15:8], val=rom_data[7:0]. Go to TX.
- Address advance: rom_addr increments when leaving DELAY or GAP, and on the xx=0 path. If rom_addr would pass 2^ROM_AW-1, go to DONE instead; the address never wraps.
- DONE: busy=0 and done=1 in the same cycle; sioc=1, siod_oe=0.
- TX frame, driven by a quarter-tick counter of Q cycles:
  - Start: siod_oe=1, siod_o=0 while sioc=1, held 2Q.
  - 27 bit slots of 4Q each, in the order DEV_ADDR[7:0], don't-care, reg[7:0], don't-care, val[7:0], don't-care. Data bits are MSB first.
  - Within a slot: q0 sioc=0 and siod updates; q1 sioc=0; q2 and q3 sioc=1.
  - Don't-care slots: siod_oe=0 for the whole slot. The sampled SIOD value is ignored; no retry.
  - Stop: one slot with siod_o=0 and siod_oe=1, sioc rises at q2; siod_o=1 at the end of q3. Then hold 2Q.
  - Total frame length: 116*Q cycles (3480 at the defaults).
- GAP: increment writes_done, wait 4Q cycles with the bus idle, then advance.
- Reset asserted mid-frame: immediate return to reset values. The bus is released (sioc=1, oe=0) with no stop condition; the sensor recovers on the next start condition.
- Simultaneous start edge and DONE entry: the edge is ignored (busy was still 1 in that cycle).

Test Plan:
- Reset, then start pulse, table [0x1280, 0xFFFF], defaults:
  - busy rises next cycle; first SIOC falling edge after 10000+ cycles;
  - bits on siod: 0x42, Z, 0x12, Z, 0x80, Z; frame length 3480 cycles;
  - then done=1, busy=0, writes_done=1.
- Table [0xF002, 0x1101, 0xFFFF]: the gap between the end of power-up and the frame start is at least 24000 cycles; writes_done=1 at end.
- Table fully populated with writes and no end marker, ROM_AW=2: exactly 4 frames, done=1, rom_addr stays 3 (no wrap).
- Second start pulse mid-sequence: ignored, frame sequence unchanged. Start after done: done drops and the sequence reruns with writes_done restarting at 0.
- rst low for 1 cycle at bit 10 of frame 2: sioc=1 and siod_oe=0 immediately; busy=0, done=0; no further SIOC activity until the next start.
- Q check with CLK_FREQ=4000000, SCCB_FREQ=400000: Q=2, frame length 232 cycles. Verify SIOC high is never shorter than 2Q and siod never changes while sioc=1 except at start/stop.

Source files
------------

// File: rtl/sccb_init_sequencer.sv
// sccb_init_sequencer: walks a 16-bit register ROM and issues one SCCB 3-phase write per entry.
// Ports:
//   clk, rst (async, active-low)  clock and reset
//   start                          rising edge begins a sequence while idle or done
//   rom_addr / rom_data            table address out, {reg, val} entry back one cycle later
//   sioc, siod_o, siod_oe          SCCB clock, data value and data drive enable (0 = released)
//   busy, done, writes_done        run status and count of completed writes
//   debug_out                      {state, 3'b0, done, writes_done[7:0], rom_addr[15:0]}
module sccb_init_sequencer #(
  parameter int          CLK_FREQ      = 12000000,
  parameter int          SCCB_FREQ     = 100000,
  parameter int          POWERUP_DELAY = 10000,
  parameter logic [7:0]  DEV_ADDR      = 8'h42,
  parameter int          ROM_AW        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sioc,
  output logic              siod_o,
  output logic              siod_oe,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW:0]   writes_done,
  output logic [31:0]       debug_out
);
  localparam int          QR   = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int          Q    = (QR < 1) ? 1 : QR;
  localparam logic [15:0] QM1  = 16'(Q - 1);
  localparam logic [31:0] GAPN = 32'(4 * Q - 1);
  localparam logic [31:0] MS   = 32'(CLK_FREQ / 1000);
  localparam logic [31:0] PU   = 32'(POWERUP_DELAY);
  // drive enable per bit slot: the ninth slot of each byte is released for the don't-care bit
  localparam logic [31:0] MASK = {5'd0, 8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};
  typedef enum logic [3:0] {S_IDLE, S_PWRUP, S_FETCH, S_WAITROM, S_DECODE, S_TX, S_GAP, S_DELAY, S_DONE} state_t;
  state_t            r_state;
  logic              r_start_d, r_sioc, r_siod, r_oe, r_busy, r_done;
  logic [31:0]       r_cnt;
  logic [15:0]       r_qcnt;
  logic [6:0]        r_k;
  logic [7:0]        r_reg, r_val;
  logic [ROM_AW-1:0] r_addr;
  logic [ROM_AW:0]   r_wd;
  logic              w_rise, w_adv, w_last, w_tx, w_sioc, w_siod, w_oe;
  logic [4:0]        w_s, w_idx;
  logic [31:0]       w_frame;
  assign w_rise  = start & ~r_start_d;
  assign w_last  = &r_addr;
  assign w_frame = {5'd0, DEV_ADDR, 1'b1, r_reg, 1'b1, r_val, 1'b1};
  assign w_s     = 5'((r_k - 7'd2) >> 2);
  // r_k counts quarter periods across the 116-quarter frame: 2 start, 27 bit slots, stop slot, 2 hold
  always_comb begin
    w_idx  = 5'd26 - w_s;
    w_tx   = r_state == S_TX;
    w_sioc = !w_tx || r_k < 7'd2 || r_k > 7'd113 || !r_k[1];
    w_siod = !w_tx || r_k > 7'd113 || (r_k > 7'd1 && r_k < 7'd110 && w_frame[w_idx]);
    w_oe   = w_tx && (r_k < 7'd2 || r_k > 7'd109 || MASK[w_idx]);
    w_adv  = ((r_state == S_GAP || r_state == S_DELAY) && r_cnt == 32'd0) ||
             (r_state == S_DECODE && rom_data == 16'hF000);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_start_d <= 1'b0;
      r_sioc    <= 1'b1;
      r_siod    <= 1'b1;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_qcnt    <= '0;
      r_k       <= '0;
      r_reg     <= '0;
      r_val     <= '0;
      r_addr    <= '0;
      r_wd      <= '0;
    end else begin
      r_start_d <= start;
      r_sioc    <= w_sioc;
      r_siod    <= w_siod;
      r_oe      <= w_oe;
      case (r_state)
        S_IDLE, S_DONE: if (w_rise) begin
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_addr  <= '0;
          r_wd    <= '0;
          r_cnt   <= PU;
          r_state <= S_PWRUP;
        end
        S_PWRUP: if (r_cnt == 32'd0) r_state <= S_FETCH; else r_cnt <= r_cnt - 32'd1;
        S_FETCH: r_state <= S_WAITROM;
        S_WAITROM: r_state <= S_DECODE;
        S_DECODE: if (rom_data == 16'hFFFF) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else if (rom_data[15:8] == 8'hF0) begin
          r_cnt   <= {24'd0, rom_data[7:0]} * MS;
          r_state <= S_DELAY;
        end else begin
          r_reg   <= rom_data[15:8];
          r_val   <= rom_data[7:0];
          r_qcnt  <= '0;
          r_k     <= '0;
          r_state <= S_TX;
        end
        S_TX: if (r_qcnt == QM1) begin
          r_qcnt <= '0;
          if (r_k == 7'd115) begin
            r_k     <= '0;
            r_wd    <= r_wd + 1'b1;
            r_cnt   <= GAPN;
            r_state <= S_GAP;
          end else r_k <= r_k + 7'd1;
        end else r_qcnt <= r_qcnt + 16'd1;
        S_GAP, S_DELAY: if (r_cnt != 32'd0) r_cnt <= r_cnt - 32'd1;
        default: r_state <= S_IDLE;
      endcase
      // moving to the next entry; the last address ends the run instead of wrapping
      if (w_adv) begin
        if (w_last) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else begin
          r_addr  <= r_addr + 1'b1;
          r_state <= S_FETCH;
        end
      end
    end
  end
  assign rom_addr    = r_addr;
  assign sioc        = r_sioc;
  assign siod_o      = r_siod;
  assign siod_oe     = r_oe;
  assign busy        = r_busy;
  assign done        = r_done;
  assign writes_done = r_wd;
  assign debug_out   = {r_state, 3'b000, r_done, 8'(r_wd), 16'(r_addr)};
endmodule

// File: tb/tb_sccb_init_sequencer.sv
// tb_sccb_init_sequencer: bus-level checks of the SCCB init sequencer at default and fast settings.
module tb_sccb_init_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, start_a, start_f;
  logic [7:0]  addr_a;
  logic [1:0]  addr_f;
  logic [15:0] rd_a, rd_f;
  logic        sioc_a, sdo_a, oe_a, busy_a, done_a;
  logic        sioc_f, sdo_f, oe_f, busy_f, done_f;
  logic [8:0]  wd_a;
  logic [2:0]  wd_f;
  logic [31:0] dbg_a, dbg_f;
  logic [15:0] rom_a [256];
  logic [15:0] rom_f [4];
  always @(posedge clk) begin
    rd_a <= rom_a[addr_a];
    rd_f <= rom_f[addr_f];
  end
  sccb_init_sequencer u_a (
    .clk(clk), .rst(rst), .start(start_a), .rom_addr(addr_a), .rom_data(rd_a),
    .sioc(sioc_a), .siod_o(sdo_a), .siod_oe(oe_a), .busy(busy_a), .done(done_a),
    .writes_done(wd_a), .debug_out(dbg_a));
  sccb_init_sequencer #(.CLK_FREQ(4000000), .SCCB_FREQ(400000), .POWERUP_DELAY(20), .ROM_AW(2)) u_f (
    .clk(clk), .rst(rst), .start(start_f), .rom_addr(addr_f), .rom_data(rd_f),
    .sioc(sioc_f), .siod_o(sdo_f), .siod_oe(oe_f), .busy(busy_f), .done(done_f),
    .writes_done(wd_f), .debug_out(dbg_f));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct { logic [7:0] dev, rg, val; logic [27:0] oes; int len; int nb; int t0; } frame_t;
  frame_t fq[2][$];
  bit p_s[2] = '{1'b1, 1'b1};
  bit p_l[2] = '{1'b1, 1'b1};
  bit p_o[2], in_f[2], stp[2];
  int nb[2], t0[2], hs[2], glitch[2], shorthi[2], falls[2];
  int first_fall[2] = '{-1, -1};
  int qq[2] = '{30, 2};
  logic [27:0] bits[2], oes[2];
  localparam logic [27:0] DCM = {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
  // bus decoder: start/stop conditions, bits sampled on SIOC rising, released SIOD reads as 1
  always @(negedge clk) begin
    bit s, l, o;
    frame_t f;
    for (int i = 0; i < 2; i++) begin
      s = i ? sioc_f : sioc_a;
      o = i ? oe_f : oe_a;
      l = o ? (i ? sdo_f : sdo_a) : 1'b1;
      if (!rst) begin
        in_f[i] = 1'b0;
        stp[i] = 1'b0;
      end else begin
        if (p_s[i] && s && p_l[i] && !l) begin
          in_f[i] = 1'b1; stp[i] = 1'b0; nb[i] = 0; t0[i] = cyc;
        end else if (p_s[i] && s && !p_l[i] && l && in_f[i] && !stp[i]) stp[i] = 1'b1;
        else if (p_s[i] && s && p_l[i] != l) glitch[i]++;
        if (!p_s[i] && s) begin
          hs[i] = cyc;
          if (in_f[i] && !stp[i] && nb[i] < 28) begin
            bits[i][27-nb[i]] = l;
            oes[i][27-nb[i]] = o;
            nb[i]++;
          end
        end
        if (p_s[i] && !s) begin
          falls[i]++;
          if (first_fall[i] < 0) first_fall[i] = cyc;
          if (cyc - hs[i] < 2 * qq[i]) shorthi[i]++;
        end
        if (stp[i] && p_o[i] && !o) begin
          f.dev = bits[i][27:20]; f.rg = bits[i][18:11]; f.val = bits[i][9:2];
          f.oes = oes[i]; f.len = cyc - t0[i]; f.nb = nb[i]; f.t0 = t0[i];
          fq[i].push_back(f);
          in_f[i] = 1'b0; stp[i] = 1'b0;
        end
      end
      p_s[i] = s; p_l[i] = l; p_o[i] = o;
    end
  end
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic pulse(input int i);
    @(negedge clk);
    if (i != 0) start_f = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_f = 1'b0;
  endtask
  task automatic wait_done(input int i, input int budget, input string nm);
    int n = 0;
    while (!(i != 0 ? done_f : done_a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " done"}, 32'(i != 0 ? done_f : done_a), 32'd1);
  endtask
  // reference: writes are the non-delay entries up to the first end marker, stopping at the last address
  logic [15:0] exp_q[$];
  int exp_addr;
  task automatic model(input logic [63:0] t);
    logic [15:0] e;
    exp_q.delete();
    exp_addr = 0;
    for (int k = 0; k < 4; k++) begin
      e = t[63-16*k -: 16];
      exp_addr = k;
      if (e == 16'hFFFF) break;
      if (e[15:8] != 8'hF0) exp_q.push_back(e);
    end
  endtask
  task automatic chk_frames(input int i, input string nm);
    chk({nm, " nframes"}, 32'(fq[i].size()), 32'(exp_q.size()));
    for (int j = 0; j < fq[i].size() && j < exp_q.size(); j++) begin
      chk($sformatf("%s f%0d bytes", nm, j), 32'({fq[i][j].dev, fq[i][j].rg, fq[i][j].val}), 32'({8'h42, exp_q[j]}));
      chk($sformatf("%s f%0d len", nm, j), 32'(fq[i][j].len), 32'(116 * qq[i]));
      chk($sformatf("%s f%0d oe", nm, j), 32'(fq[i][j].oes), 32'(DCM));
      chk($sformatf("%s f%0d nbits", nm, j), 32'(fq[i][j].nb), 32'd28);
    end
  endtask
  task automatic load_f(input logic [63:0] t);
    for (int k = 0; k < 4; k++) rom_f[k] = t[63-16*k -: 16];
  endtask
  task automatic run_f(input logic [63:0] t, input string nm);
    load_f(t);
    model(t);
    fq[1].delete();
    pulse(1);
    wait_done(1, 30000, nm);
    chk_frames(1, nm);
    chk({nm, " wd"}, 32'(wd_f), 32'(exp_q.size()));
    chk({nm, " addr"}, 32'(addr_f), 32'(exp_addr));
    chk({nm, " busy"}, 32'(busy_f), 32'd0);
  endtask
  typedef struct { logic [63:0] t; int nfr; int wd; int addr; } vec_t;
  vec_t vecs[5];
  initial begin
    int tp, n, f0;
    logic [63:0] t;
    vecs[0] = '{64'h1111_2222_3333_4444, 4, 4, 3};
    vecs[1] = '{64'hA1B2_FFFF_1234_5678, 1, 1, 1};
    vecs[2] = '{64'hF000_C3C4_FFFF_0000, 1, 1, 2};
    vecs[3] = '{64'hFFFF_1111_2222_3333, 0, 0, 0};
    vecs[4] = '{64'hF001_F000_5A5A_F000, 1, 1, 3};
    for (int k = 0; k < 256; k++) rom_a[k] = 16'hFFFF;
    for (int k = 0; k < 4; k++) rom_f[k] = 16'hFFFF;
    rst = 1'b0; start_a = 1'b0; start_f = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst sioc", 32'(sioc_a), 32'd1);
    chk("rst siod", 32'(sdo_a), 32'd1);
    chk("rst oe", 32'(oe_a), 32'd0);
    chk("rst busy", 32'(busy_a), 32'd0);
    chk("rst done", 32'(done_a), 32'd0);
    chk("rst addr", 32'(addr_a), 32'd0);
    chk("rst wd", 32'(wd_a), 32'd0);
    chk("rst dbg", 32'(dbg_a[27:0]), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // one write then end marker, default timing
    rom_a[0] = 16'h1280;
    model(64'h1280_FFFF_FFFF_FFFF);
    fq[0].delete();
    first_fall[0] = -1;
    pulse(0);
    tp = cyc;
    chk("t1 busy rise", 32'(busy_a), 32'd1);
    wait_done(0, 20000, "t1");
    chk("t1 first fall min", 32'(first_fall[0] - tp >= 10000), 32'd1);
    chk("t1 first fall max", 32'(first_fall[0] - tp < 10200), 32'd1);
    chk_frames(0, "t1");
    chk("t1 busy", 32'(busy_a), 32'd0);
    chk("t1 wd", 32'(wd_a), 32'd1);
    chk("t1 addr", 32'(addr_a), 32'd1);
    chk("t1 dbg", 32'(dbg_a[27:0]), 32'h1010001);
    // 2 ms delay ahead of the write
    rom_a[0] = 16'hF002; rom_a[1] = 16'h1101; rom_a[2] = 16'hFFFF;
    model(64'hF002_1101_FFFF_FFFF);
    fq[0].delete();
    pulse(0);
    tp = cyc;
    wait_done(0, 60000, "t2");
    chk_frames(0, "t2");
    chk("t2 delay", 32'(((fq[0].size() > 0) ? fq[0][0].t0 : tp) - tp >= 34000), 32'd1);
    chk("t2 wd", 32'(wd_a), 32'd1);
    chk("t2 addr", 32'(addr_a), 32'd2);
    // directed tables on the fast, 4-entry instance
    for (int v = 0; v < 5; v++) begin
      run_f(vecs[v].t, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d nfr", v), 32'(fq[1].size()), 32'(vecs[v].nfr));
      chk($sformatf("vec%0d wdc", v), 32'(wd_f), 32'(vecs[v].wd));
      chk($sformatf("vec%0d addrc", v), 32'(addr_f), 32'(vecs[v].addr));
    end
    // random tables
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        n = $urandom_range(0, 5);
        t[63-16*k -: 16] = (n == 0) ? 16'hFFFF : (n == 1) ? 16'hF000 :
                           {8'($urandom_range(0, 8'hEF)), 8'($urandom)};
      end
      run_f(t, $sformatf("rnd%0d", r));
    end
    // start while busy is ignored, start after done reruns from zero
    t = 64'h1111_2222_3333_4444;
    load_f(t);
    model(t);
    fq[1].delete();
    pulse(1);
    repeat (300) @(negedge clk);
    pulse(1);
    wait_done(1, 30000, "restart busy");
    chk_frames(1, "restart busy");
    fq[1].delete();
    pulse(1);
    chk("rerun done drop", 32'(done_f), 32'd0);
    chk("rerun wd zero", 32'(wd_f), 32'd0);
    chk("rerun busy", 32'(busy_f), 32'd1);
    wait_done(1, 30000, "rerun");
    chk_frames(1, "rerun");
    chk("rerun wd", 32'(wd_f), 32'd4);
    // reset pulse in the middle of the second frame
    fq[1].delete();
    pulse(1);
    n = 0;
    while (!(fq[1].size() == 1 && in_f[1] && nb[1] == 10) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rst reach frame2", 32'(n < 5000), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst sioc", 32'(sioc_f), 32'd1);
    chk("midrst oe", 32'(oe_f), 32'd0);
    chk("midrst busy", 32'(busy_f), 32'd0);
    chk("midrst done", 32'(done_f), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    f0 = falls[1];
    repeat (2000) @(negedge clk);
    chk("midrst quiet", 32'(falls[1]), 32'(f0));
    chk("midrst busy2", 32'(busy_f), 32'd0);
    chk("midrst wd", 32'(wd_f), 32'd0);
    run_f(t, "recover");
    chk("glitch a", 32'(glitch[0]), 32'd0);
    chk("glitch f", 32'(glitch[1]), 32'd0);
    chk("short high a", 32'(shorthi[0]), 32'd0);
    chk("short high f", 32'(shorthi[1]), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
